// File: rtl/eth_img_depkt_pkg.sv
// rtl/eth_img_depkt_pkg.sv - shared constants and FSM encoding for the image (de)packetiser
package eth_img_depkt_pkg;

    localparam logic [31:0] DEF_IMG_FRAME_HEAD = 32'hF05A_A50F;
    localparam logic [31:0] DEF_FIRST_SEQ      = 32'd1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEQ   = 3'd1,
        ST_HEAD  = 3'd2,
        ST_RES   = 3'd3,
        ST_PIXEL = 3'd4,
        ST_DROP  = 3'd5
    } depkt_state_e;

endpackage

// File: rtl/eth_img_px_split.sv
// rtl/eth_img_px_split.sv - splits 32-bit payload words into two RGB565 pixels
module eth_img_px_split (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        px_valid,
    output logic [15:0] px_data,
    output logic        overrun
);

    logic        pending;
    logic [15:0] low_q;

    // A new word always wins over a pending low half; losing that half is the overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_valid <= 1'b0;
            px_data  <= 16'h0000;
            overrun  <= 1'b0;
            pending  <= 1'b0;
            low_q    <= 16'h0000;
        end else begin
            overrun <= 1'b0;
            if (flush) begin
                px_valid <= 1'b0;
                pending  <= 1'b0;
            end else if (word_valid) begin
                px_valid <= 1'b1;
                px_data  <= word_data[31:16];
                low_q    <= word_data[15:0];
                overrun  <= pending;
                pending  <= 1'b1;
            end else if (pending) begin
                px_valid <= 1'b1;
                px_data  <= low_q;
                pending  <= 1'b0;
            end else begin
                px_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/eth_img_depkt.sv
// rtl/eth_img_depkt.sv - UDP payload depacketiser recovering resolution and RGB565 pixels
module eth_img_depkt
    import eth_img_depkt_pkg::*;
#(
    parameter logic [31:0] IMG_FRAME_HEAD = DEF_IMG_FRAME_HEAD,
    parameter logic [31:0] FIRST_SEQ      = DEF_FIRST_SEQ
) (
    input  logic        eth_rx_clk,
    input  logic        rst_n,
    input  logic        transfer_flag,
    input  logic        rec_en,
    input  logic [31:0] rec_data,
    input  logic        rec_pkt_done,
    output logic        img_data_en,
    output logic [15:0] img_data,
    output logic        frame_start,
    output logic [15:0] img_h_pixel,
    output logic [15:0] img_v_pixel,
    output logic        seq_err,
    output logic        head_err,
    output logic        overrun
);

    depkt_state_e state, state_nxt;
    logic         synced, synced_nxt;
    logic [31:0]  expected_seq, expected_seq_nxt;
    logic         seq_err_nxt, head_err_nxt, frame_start_nxt;
    logic         res_load, px_word_valid;
    logic [1:0]   rst_sync;
    logic         rst_int_n;

    // Reset asserts immediately but releases only after two clean receive-clock edges.
    always_ff @(posedge eth_rx_clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

    always_ff @(posedge eth_rx_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state        <= ST_IDLE;
            synced       <= 1'b0;
            expected_seq <= FIRST_SEQ + 32'd1;
            seq_err      <= 1'b0;
            head_err     <= 1'b0;
            frame_start  <= 1'b0;
            img_h_pixel  <= 16'h0000;
            img_v_pixel  <= 16'h0000;
        end else begin
            state        <= state_nxt;
            synced       <= synced_nxt;
            expected_seq <= expected_seq_nxt;
            seq_err      <= seq_err_nxt;
            head_err     <= head_err_nxt;
            frame_start  <= frame_start_nxt;
            if (res_load) begin
                img_h_pixel <= rec_data[31:16];
                img_v_pixel <= rec_data[15:0];
            end
        end
    end

    always_comb begin
        state_nxt        = state;
        synced_nxt       = synced;
        expected_seq_nxt = expected_seq;
        seq_err_nxt      = 1'b0;
        head_err_nxt     = 1'b0;
        frame_start_nxt  = 1'b0;
        res_load         = 1'b0;
        px_word_valid    = 1'b0;
        if (!transfer_flag) begin
            state_nxt  = ST_IDLE;
            synced_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt  = ST_SEQ;
                    synced_nxt = 1'b0;
                end
                ST_SEQ: if (rec_en) begin
                    if (rec_data == FIRST_SEQ) begin
                        state_nxt        = ST_HEAD;
                        synced_nxt       = 1'b1;
                        expected_seq_nxt = FIRST_SEQ + 32'd1;
                    end else if (synced && rec_data == expected_seq) begin
                        state_nxt        = ST_PIXEL;
                        expected_seq_nxt = expected_seq + 32'd1;
                    end else begin
                        state_nxt   = ST_DROP;
                        seq_err_nxt = synced;
                        synced_nxt  = 1'b0;
                    end
                end
                ST_HEAD: if (rec_en) begin
                    if (rec_data == IMG_FRAME_HEAD) begin
                        state_nxt = ST_RES;
                    end else begin
                        state_nxt    = ST_DROP;
                        head_err_nxt = 1'b1;
                        synced_nxt   = 1'b0;
                    end
                end
                ST_RES: if (rec_en) begin
                    res_load        = 1'b1;
                    frame_start_nxt = 1'b1;
                    state_nxt       = ST_PIXEL;
                end
                ST_PIXEL: px_word_valid = rec_en;
                ST_DROP:  state_nxt = ST_DROP;
                default:  state_nxt = ST_IDLE;
            endcase
            // The word of this cycle is already folded into state_nxt; a packet ending
            // before the resolution word counts as a truncated header.
            if (rec_pkt_done) begin
                if (state_nxt == ST_HEAD || state_nxt == ST_RES) begin
                    head_err_nxt = 1'b1;
                    synced_nxt   = 1'b0;
                end
                state_nxt = ST_SEQ;
            end
        end
    end

    eth_img_px_split u_px_split (
        .clk        (eth_rx_clk),
        .rst_n      (rst_int_n),
        .flush      (!transfer_flag),
        .word_valid (px_word_valid),
        .word_data  (rec_data),
        .px_valid   (img_data_en),
        .px_data    (img_data),
        .overrun    (overrun)
    );

endmodule

// File: tb/tb_eth_img_depkt.sv
// tb/tb_eth_img_depkt.sv - scoreboard bench for eth_img_depkt
module tb_eth_img_depkt;

    logic        clk;
    logic        rst_n;
    logic        transfer_flag;
    logic        rec_en;
    logic [31:0] rec_data;
    logic        rec_pkt_done;
    logic        img_data_en;
    logic [15:0] img_data;
    logic        frame_start;
    logic [15:0] img_h_pixel;
    logic [15:0] img_v_pixel;
    logic        seq_err;
    logic        head_err;
    logic        overrun;

    int n_vec = 0;
    int n_err = 0;
    int n_fs  = 0;
    int n_seq = 0;
    int n_head = 0;
    int n_ovr = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] HEAD = 32'hF05A_A50F;

    eth_img_depkt dut (
        .eth_rx_clk    (clk),
        .rst_n         (rst_n),
        .transfer_flag (transfer_flag),
        .rec_en        (rec_en),
        .rec_data      (rec_data),
        .rec_pkt_done  (rec_pkt_done),
        .img_data_en   (img_data_en),
        .img_data      (img_data),
        .frame_start   (frame_start),
        .img_h_pixel   (img_h_pixel),
        .img_v_pixel   (img_v_pixel),
        .seq_err       (seq_err),
        .head_err      (head_err),
        .overrun       (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (img_data_en) begin
            logic [31:0] e;
            e = 32'hFFFF_FFFF;
            if (exp_q.size() != 0) e = exp_q.pop_front();
            check_eq("pixel", {16'h0000, img_data}, e);
        end
        if (frame_start) n_fs++;
        if (seq_err)     n_seq++;
        if (head_err)    n_head++;
        if (overrun)     n_ovr++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w);
        rec_en   = 1'b1;
        rec_data = w;
        tick();
        rec_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic send_done();
        rec_pkt_done = 1'b1;
        tick();
        rec_pkt_done = 1'b0;
        repeat (3) tick();
    endtask

    task automatic exp_word(input logic [31:0] w);
        exp_q.push_back({16'h0000, w[31:16]});
        exp_q.push_back({16'h0000, w[15:0]});
    endtask

    task automatic good_frame(input logic [31:0] res, input logic [31:0] px);
        exp_word(px);
        send_word(32'd1);
        send_word(HEAD);
        send_word(res);
        send_word(px);
        send_done();
    endtask

    initial begin
        rst_n         = 1'b0;
        transfer_flag = 1'b0;
        rec_en        = 1'b0;
        rec_data      = 32'h0;
        rec_pkt_done  = 1'b0;
        repeat (3) tick();
        check_eq("rst_en",   {31'h0, img_data_en}, 32'h0);
        check_eq("rst_data", {16'h0, img_data}, 32'h0);
        check_eq("rst_fs",   {31'h0, frame_start}, 32'h0);
        check_eq("rst_h",    {16'h0, img_h_pixel}, 32'h0);
        check_eq("rst_v",    {16'h0, img_v_pixel}, 32'h0);
        check_eq("rst_errs", {29'h0, seq_err, head_err, overrun}, 32'h0);

        rst_n = 1'b1;
        repeat (5) tick();
        transfer_flag = 1'b1;
        repeat (3) tick();

        good_frame(32'h03C0_021C, 32'hAAAA_BBBB);
        check_eq("f1_fs", n_fs, 1);
        check_eq("f1_h", {16'h0, img_h_pixel}, 32'd960);
        check_eq("f1_v", {16'h0, img_v_pixel}, 32'd540);

        exp_word(32'h1111_2222);
        send_word(32'd2);
        send_word(32'h1111_2222);
        send_done();
        check_eq("p2_fs", n_fs, 1);
        check_eq("p2_q", exp_q.size(), 0);

        send_word(32'd4);
        send_word(32'h3333_4444);
        send_done();
        check_eq("gap_seq_err", n_seq, 1);
        send_word(32'd5);
        send_word(32'h5555_6666);
        send_done();
        check_eq("gap_seq_err2", n_seq, 1);
        good_frame(32'h0010_0020, 32'h7777_8888);
        check_eq("resync_fs", n_fs, 2);
        check_eq("resync_h", {16'h0, img_h_pixel}, 32'd16);
        check_eq("resync_v", {16'h0, img_v_pixel}, 32'd32);

        send_word(32'd1);
        send_word(32'h1234_5678);
        send_word(32'h0040_0040);
        send_word(32'h9999_AAAA);
        send_done();
        check_eq("badhead_err", n_head, 1);
        check_eq("badhead_fs", n_fs, 2);
        check_eq("badhead_h", {16'h0, img_h_pixel}, 32'd16);

        exp_q.push_back(32'h0000_CAFE);
        exp_q.push_back(32'h0000_BEEF);
        exp_q.push_back(32'h0000_5678);
        send_word(32'd1);
        send_word(HEAD);
        send_word(32'h0020_0010);
        rec_en   = 1'b1;
        rec_data = 32'hCAFE_1234;
        tick();
        rec_data = 32'hBEEF_5678;
        tick();
        rec_en = 1'b0;
        repeat (3) tick();
        send_done();
        check_eq("ovr_cnt", n_ovr, 1);
        check_eq("ovr_fs", n_fs, 3);
        check_eq("ovr_q", exp_q.size(), 0);

        send_word(32'd2);
        exp_q.push_back(32'h0000_ABCD);
        rec_en   = 1'b1;
        rec_data = 32'hABCD_0123;
        tick();
        rec_en        = 1'b0;
        transfer_flag = 1'b0;
        tick();
        check_eq("abort_en", {31'h0, img_data_en}, 32'h0);
        repeat (3) tick();
        transfer_flag = 1'b1;
        repeat (3) tick();
        send_word(32'd2);
        send_word(32'h0F0F_0F0F);
        send_done();
        check_eq("abort_seq_err", n_seq, 1);
        good_frame(32'h0280_01E0, 32'h1357_2468);
        check_eq("abort_fs", n_fs, 4);
        check_eq("abort_h", {16'h0, img_h_pixel}, 32'd640);

        send_word(32'd2);
        rec_en   = 1'b1;
        rec_data = 32'h2468_1357;
        tick();
        rec_en = 1'b0;
        rst_n  = 1'b0;
        tick();
        check_eq("rstmid_en", {31'h0, img_data_en}, 32'h0);
        check_eq("rstmid_h", {16'h0, img_h_pixel}, 32'h0);
        check_eq("rstmid_v", {16'h0, img_v_pixel}, 32'h0);
        rst_n = 1'b1;
        repeat (5) tick();
        send_word(32'd2);
        send_word(32'h1111_1111);
        send_done();
        good_frame(32'h0100_0080, 32'hFEDC_BA98);
        check_eq("rstmid_fs", n_fs, 5);
        check_eq("rstmid_v2", {16'h0, img_v_pixel}, 32'd128);
        check_eq("final_head_err", n_head, 1);
        check_eq("final_ovr", n_ovr, 1);
        check_eq("final_q", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
